residual_add: RTL

- Residual-connection stage that sits directly upstream of the layer-normalisation block in each transformer sub-layer.
- Adds the sub-layer output (attention or MLP result) element-wise to the saved residual input, with signed saturation.
- Presents the sum as one flattened (SEQ_LEN, EMB_DIM) matrix plus a done/out_valid pulse, which drives the layer-norm start/x_in directly.
- Processes one element per cycle under a small FSM; also reports how many elements saturated.

---
 rtl/tva_pkg.sv | 47 ++++
 rtl/residual_add.sv | 124 ++++++++++++
 2 files changed

// File: rtl/tva_pkg.sv
// Shared types and the saturating-add helper for the residual adder.
// Holds the FSM state encoding and a width-generic signed saturating add.
package tva_pkg;

    localparam int MAX_DW = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [MAX_DW-1:0] sum;
        logic              ovf;
    } sat_res_t;

    // Operands arrive sign-extended to MAX_DW; dw is the real element
    // width. The sum is clamped to the dw-bit signed range and returned
    // sign-extended, with ovf set when clamping happened.
    function automatic sat_res_t sat_add(
        input logic [MAX_DW-1:0] a,
        input logic [MAX_DW-1:0] b,
        input int unsigned       dw
    );
        logic signed [MAX_DW:0] s;
        logic signed [MAX_DW:0] one;
        logic signed [MAX_DW:0] hi;
        logic signed [MAX_DW:0] lo;
        sat_res_t               r;
        one = (MAX_DW+1)'(1);
        s   = $signed({a[MAX_DW-1], a}) + $signed({b[MAX_DW-1], b});
        hi  = (one <<< (dw - 1)) - one;
        lo  = -(one <<< (dw - 1));
        r.ovf = 1'b1;
        if (s > hi) begin
            r.sum = hi[MAX_DW-1:0];
        end else if (s < lo) begin
            r.sum = lo[MAX_DW-1:0];
        end else begin
            r.sum = s[MAX_DW-1:0];
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/residual_add.sv
// Residual connection: x = sat(res + sub), one element per cycle.
// Ports: start/busy handshake, flat res_in/sub_in/x_out, sat_count, done/out_valid.
module residual_add
    import tva_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int SEQ_LEN    = 8,
    parameter  int EMB_DIM    = 8,
    localparam int N_ELEM     = SEQ_LEN * EMB_DIM,
    localparam int CNT_W      = $clog2(N_ELEM + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    input  logic [DATA_WIDTH*N_ELEM-1:0] res_in,
    input  logic [DATA_WIDTH*N_ELEM-1:0] sub_in,
    output logic [DATA_WIDTH*N_ELEM-1:0] x_out,
    output logic [CNT_W-1:0]             sat_count,
    output logic                         done,
    output logic                         out_valid
);

    localparam int VEC_W = DATA_WIDTH * N_ELEM;
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   sat_acc_q, sat_acc_d;
    logic [VEC_W-1:0]   a_q, a_d;
    logic [VEC_W-1:0]   b_q, b_d;
    logic [VEC_W-1:0]   sum_q, sum_d;
    logic [VEC_W-1:0]   x_out_q, x_out_d;
    logic [CNT_W-1:0]   sat_cnt_q, sat_cnt_d;
    logic               done_q, done_d;
    sat_res_t           sr;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sat_acc_d = sat_acc_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        x_out_d   = x_out_q;
        sat_cnt_d = sat_cnt_q;
        done_d    = 1'b0;

        sr = sat_add(
            MAX_DW'(signed'(a_q[idx_q*DATA_WIDTH +: DATA_WIDTH])),
            MAX_DW'(signed'(b_q[idx_q*DATA_WIDTH +: DATA_WIDTH])),
            DATA_WIDTH
        );

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = res_in;
                    b_d       = sub_in;
                    idx_d     = '0;
                    sat_acc_d = '0;
                    state_d   = S_ADD;
                end
            end
            S_ADD: begin
                sum_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = sr.sum[DATA_WIDTH-1:0];
                if (sr.ovf) begin
                    sat_acc_d = sat_acc_q + CNT_W'(1);
                end
                if (idx_q == IDX_W'(N_ELEM - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                x_out_d   = sum_q;
                sat_cnt_d = sat_acc_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Upper bits of the helper result are only sign extension.
    if (DATA_WIDTH < MAX_DW) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^sr.sum[MAX_DW-1:DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            sat_acc_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            x_out_q   <= '0;
            sat_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sat_acc_q <= sat_acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            x_out_q   <= x_out_d;
            sat_cnt_q <= sat_cnt_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign x_out     = x_out_q;
    assign sat_count = sat_cnt_q;
    assign done      = done_q;
    assign out_valid = done_q;

endmodule
